// File: rtl/shift_pkg.sv
// Shared types for the shift sequencer: operation encoding and FSM states.
package shift_pkg;

   // The low two bits keep the legacy 4-bit shifter encoding.
   typedef enum logic [2:0] {
      OP_PASS = 3'b000,
      OP_LSL  = 3'b001,
      OP_LSR  = 3'b010,
      OP_CLR  = 3'b011,
      OP_ROL  = 3'b100,
      OP_ROR  = 3'b101,
      OP_ASR  = 3'b110,
      OP_RSVD = 3'b111
   } shift_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// One single-bit shift/rotate step; combinational.
module shift_step
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_value,
   input  shift_op_t        i_op,
   input  logic             i_il,
   input  logic             i_ir,
   output logic [WIDTH-1:0] o_next,
   output logic             o_out
);

   always_comb begin
      o_next = i_value;
      o_out  = 1'b0;
      case (i_op)
         OP_LSL: begin
            o_next = {i_value[WIDTH-2:0], i_il};
            o_out  = i_value[WIDTH-1];
         end
         OP_LSR: begin
            o_next = {i_ir, i_value[WIDTH-1:1]};
            o_out  = i_value[0];
         end
         OP_ROL: begin
            o_next = {i_value[WIDTH-2:0], i_value[WIDTH-1]};
            o_out  = i_value[WIDTH-1];
         end
         OP_ROR: begin
            o_next = {i_value[0], i_value[WIDTH-1:1]};
            o_out  = i_value[0];
         end
         OP_ASR: begin
            o_next = {i_value[WIDTH-1], i_value[WIDTH-1:1]};
            o_out  = i_value[0];
         end
         default: begin
            o_next = i_value;
            o_out  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: captures an operand on start, steps one bit per clock,
// pulses done on completion.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  shift_op_t        op,
   input  logic [AMT_W-1:0] amount,
   input  logic [WIDTH-1:0] data,
   input  logic             il,
   input  logic             ir,
   input  logic             abort,
   output logic [WIDTH-1:0] result,
   output logic             shout,
   output logic             busy,
   output logic             done
);

   shift_state_t     r_state;
   shift_state_t     w_state_nxt;
   shift_op_t        r_op;
   logic             r_il;
   logic             r_ir;
   logic [AMT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_shout;
   logic [WIDTH-1:0] w_step_val;
   logic             w_step_out;
   logic             w_trivial;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .i_value (r_result),
      .i_op    (r_op),
      .i_il    (r_il),
      .i_ir    (r_ir),
      .o_next  (w_step_val),
      .o_out   (w_step_out)
   );

   assign w_trivial = (op == OP_PASS) || (op == OP_CLR) || (op == OP_RSVD) ||
                      (amount == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      busy        = (r_state != ST_IDLE);
      done        = (r_state == ST_DONE);
      case (r_state)
         ST_IDLE:  if (start) w_state_nxt = w_trivial ? ST_DONE : ST_SHIFT;
         // abort takes priority over the final step
         ST_SHIFT: begin
            if (abort)                        w_state_nxt = ST_IDLE;
            else if (r_cnt == AMT_W'(1))      w_state_nxt = ST_DONE;
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_result <= '0;
         r_shout  <= 1'b0;
         r_cnt    <= '0;
         r_op     <= OP_PASS;
         r_il     <= 1'b0;
         r_ir     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_result <= (op == OP_CLR) ? '0 : data;
                  r_op     <= op;
                  r_il     <= il;
                  r_ir     <= ir;
                  r_cnt    <= amount;
               end
            end
            ST_SHIFT: begin
               if (!abort) begin
                  r_result <= w_step_val;
                  r_shout  <= w_step_out;
                  r_cnt    <= r_cnt - AMT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign result = r_result;
   assign shout  = r_shout;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized scoreboard bench for shift_sequencer against an arithmetic model.
module tb_shift_sequencer;
   import shift_pkg::*;

   localparam int W  = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   shift_op_t     op = OP_PASS;
   logic [AW-1:0] amount = '0;
   logic [W-1:0]  data = '0;
   logic          il = 1'b0;
   logic          ir = 1'b0;
   logic          abort = 1'b0;
   logic [W-1:0]  result;
   logic          shout;
   logic          busy;
   logic          done;

   typedef struct {
      logic [W-1:0] res;
      logic         so;
      int           cyc;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   logic m_shout = 1'b0;

   shift_sequencer #(.WIDTH(W), .AMT_W(AW)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .amount (amount),
      .data   (data),
      .il     (il),
      .ir     (ir),
      .abort  (abort),
      .result (result),
      .shout  (shout),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: treat a shift as a window sliding over data extended with fill bits.
   task automatic model(input shift_op_t o, input int k, input logic [W-1:0] d,
                        input logic fl, input logic fr, input logic prev,
                        output logic [W-1:0] res, output logic so, output int lat);
      logic [63:0] v;
      logic [63:0] y;
      logic [63:0] ones;
      logic [15:0] dd;
      logic [15:0] rr;
      logic        f;
      int          r;
      ones = (64'd1 << k) - 64'd1;
      res = d;
      so  = prev;
      lat = k + 1;
      if (o == OP_PASS || o == OP_CLR || o == OP_RSVD || k == 0) begin
         res = (o == OP_CLR) ? '0 : d;
         lat = 1;
      end else if (o == OP_LSL) begin
         v   = ({56'd0, d} << k) | (fl ? ones : 64'd0);
         res = v[W-1:0];
         so  = v[W];
      end else if (o == OP_LSR || o == OP_ASR) begin
         f   = (o == OP_ASR) ? d[W-1] : fr;
         v   = (f ? (ones << (W + 1)) : 64'd0) | ({56'd0, d} << 1);
         y   = v >> k;
         res = y[W:1];
         so  = y[0];
      end else begin
         r  = k % W;
         dd = {d, d};
         if (o == OP_ROL) begin
            rr  = dd << r;
            res = rr[15:8];
            so  = res[0];
         end else begin
            rr  = dd >> r;
            res = rr[7:0];
            so  = res[W-1];
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && done) begin
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
         end else begin
            e = q.pop_front();
            check("result", int'(result), int'(e.res));
            check("shout", int'(shout), int'(e.so));
            check("done_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic run_op(input shift_op_t o, input int k, input logic [W-1:0] d,
                         input logic fl, input logic fr);
      exp_t        e;
      logic [W-1:0] r;
      logic        s;
      int          lat;
      int          t;
      @(negedge clk);
      op     = o;
      amount = AW'(k);
      data   = d;
      il     = fl;
      ir     = fr;
      start  = 1'b1;
      model(o, k, d, fl, fr, m_shout, r, s, lat);
      m_shout = s;
      e.res = r;
      e.so  = s;
      e.cyc = cyc + lat;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", int'(busy), 1);
      t = 0;
      // Scramble every input while busy: nothing may be re-sampled or queued.
      while (busy && t < 40) begin
         op     = shift_op_t'($urandom_range(0, 7));
         data   = W'($urandom);
         amount = AW'($urandom);
         il     = 1'($urandom);
         ir     = 1'($urandom);
         start  = 1'($urandom);
         @(negedge clk);
         t++;
      end
      start = 1'b0;
      check("busy_cycles", t, lat);
   endtask

   initial begin
      logic [W-1:0] r;
      logic         s;
      int           lat;

      repeat (2) @(negedge clk);
      check("rst_result", int'(result), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_shout", int'(shout), 0);
      reset = 1'b0;

      run_op(OP_LSL, 3, 8'hB5, 1'b1, 1'b0);
      run_op(OP_ASR, 2, 8'h90, 1'b0, 1'b0);
      run_op(OP_ROR, 9, 8'h01, 1'b0, 1'b0);
      run_op(OP_CLR, 5, 8'hFF, 1'b0, 1'b0);
      run_op(OP_LSL, 15, 8'h5A, 1'b1, 1'b0);
      run_op(OP_LSR, 15, 8'hA5, 1'b0, 1'b0);
      run_op(OP_ASR, 12, 8'h81, 1'b0, 1'b1);
      run_op(OP_ROL, 8, 8'h3C, 1'b0, 1'b0);
      run_op(OP_LSR, 0, 8'h77, 1'b1, 1'b1);

      // Abort mid-operation, with a stray start in between.
      @(negedge clk);
      op = OP_LSR; amount = 4'd4; data = 8'hF0; il = 1'b0; ir = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; data = 8'h55;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_result", int'(result), 'h3C);
      check("abort_done", int'(done), 0);
      model(OP_LSR, 2, 8'hF0, 1'b0, 1'b0, m_shout, r, s, lat);
      m_shout = s;
      check("abort_shout", int'(shout), int'(m_shout));

      // Abort coinciding with the only step.
      @(negedge clk);
      op = OP_LSL; amount = 4'd1; data = 8'hC3; il = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_last_busy", int'(busy), 0);
      check("abort_last_result", int'(result), 'hC3);
      check("abort_last_shout", int'(shout), int'(m_shout));
      repeat (2) @(negedge clk);

      // Asynchronous reset in the middle of a shift.
      @(negedge clk);
      op = OP_ROL; amount = 4'd12; data = 8'h96; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_rst_result", int'(result), 0);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_done", int'(done), 0);
      check("async_rst_shout", int'(shout), 0);
      m_shout = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      run_op(OP_LSL, 3, 8'hB5, 1'b1, 1'b0);

      for (int i = 0; i < 150; i++) begin
         run_op(shift_op_t'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                W'($urandom), 1'($urandom), 1'($urandom));
      end

      repeat (3) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "timeout");
   end

endmodule
